// File: rtl/wb_fifo_port.sv
// wb_fifo_port: Wishbone classic slave bridging to TX/RX FIFO streams; define WB_FIFO_PORT_ERR_EN for err_o instead of stalls
module wb_fifo_port #(
    parameter int DATA_WIDTH = 8,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic                  we_i,
    input  logic                  stb_i,
    input  logic                  cyc_i,
    output logic                  ack_o,
`ifdef WB_FIFO_PORT_ERR_EN
    output logic                  err_o,
`endif
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  write_valid,
    input  logic                  write_ready,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  read_valid,
    output logic                  read_ready
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);

    if (DATA_WIDTH < 4 || DATA_WIDTH < TAW + 1 || DATA_WIDTH < RAW + 1) begin : g_bad_width
        $error("wb_fifo_port: DATA_WIDTH too small");
    end
    if (TX_DEPTH < 2 || (1 << TAW) != TX_DEPTH || RX_DEPTH < 2 || (1 << RAW) != RX_DEPTH) begin : g_bad_depth
        $error("wb_fifo_port: depths must be powers of two, 2 or more");
    end

    logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
    logic [TAW-1:0] tx_wr, tx_rd;
    logic [RAW-1:0] rx_wr, rx_rd;
    logic [TAW:0] tx_cnt;
    logic [RAW:0] rx_cnt;
    logic [DATA_WIDTH-1:0] rdata, rd_mux;
    logic ack_q, err_q, ovf;
    logic tx_full, rx_full, rx_empty, req, data_wr, data_rd, blocked, accept;
    logic tx_push, tx_pop, rx_push, rx_pop, flush, clr;

    // Stream handshakes and bus decode; a full TX still accepts a write when the head leaves that cycle
    always_comb begin
        tx_full  = tx_cnt == (TAW+1)'(TX_DEPTH);
        rx_full  = rx_cnt == (RAW+1)'(RX_DEPTH);
        rx_empty = rx_cnt == '0;
        tx_pop   = write_valid & write_ready;
        rx_push  = read_valid & read_ready;
        req      = cyc_i & stb_i & ~ack_q & ~err_q;
        data_wr  = req & we_i & (adr_i == 2'd0);
        data_rd  = req & ~we_i & (adr_i == 2'd0);
        blocked  = (data_wr & tx_full & ~tx_pop) | (data_rd & rx_empty);
        accept   = req & ~blocked;
        tx_push  = accept & data_wr;
        rx_pop   = accept & data_rd;
        flush    = accept & we_i & (adr_i == 2'd1) & dat_i[1];
        clr      = accept & we_i & (adr_i == 2'd1) & dat_i[0];
        rd_mux   = adr_i == 2'd0 ? rx_mem[rx_rd] :
                   adr_i == 2'd1 ? DATA_WIDTH'({ovf, tx_cnt == '0, ~tx_full, ~rx_empty}) :
                   adr_i == 2'd2 ? DATA_WIDTH'(rx_cnt) :
                                   DATA_WIDTH'((TAW+1)'(TX_DEPTH) - tx_cnt);
    end

    assign ack_o       = ack_q;
    assign dat_o       = rdata;
    assign write_valid = tx_cnt != '0;
    assign write_data  = tx_mem[tx_rd];
    assign read_ready  = ~rx_full;

    // FIFO storage; contents need no reset since counts gate visibility
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= dat_i;
        if (rx_push) rx_mem[rx_wr] <= read_data;
    end

    // Pointers, counts, sticky overflow, ack and read-data register; flush beats stream traffic
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
            ovf    <= 1'b0;
            ack_q  <= 1'b0;
            rdata  <= '0;
        end else begin
            ack_q <= accept;
            rdata <= accept & ~we_i ? rd_mux : rdata;
            ovf   <= (ovf & ~clr) | (read_valid & rx_full);
            if (flush) begin
                tx_wr  <= '0;
                tx_rd  <= '0;
                tx_cnt <= '0;
                rx_wr  <= '0;
                rx_rd  <= '0;
                rx_cnt <= '0;
            end else begin
                tx_wr  <= tx_push ? tx_wr + TAW'(1) : tx_wr;
                tx_rd  <= tx_pop ? tx_rd + TAW'(1) : tx_rd;
                tx_cnt <= tx_cnt + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
                rx_wr  <= rx_push ? rx_wr + RAW'(1) : rx_wr;
                rx_rd  <= rx_pop ? rx_rd + RAW'(1) : rx_rd;
                rx_cnt <= rx_cnt + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
            end
        end
    end

`ifdef WB_FIFO_PORT_ERR_EN
    assign err_o = err_q;
    // Error pulse replaces the stall for a blocked data access
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= req & blocked;
    end
`else
    assign err_q = 1'b0;
`endif
endmodule

// File: tb/tb_wb_fifo_port.sv
// tb_wb_fifo_port: directed self-checking bench for wb_fifo_port (default build)
module tb_wb_fifo_port;
    logic       clk = 1'b0, rst = 1'b1;
    logic [1:0] adr_i = '0;
    logic [7:0] dat_i = '0, dat_o, write_data, read_data = '0;
    logic       we_i = 1'b0, stb_i = 1'b0, cyc_i = 1'b0, ack_o;
    logic       write_valid, write_ready = 1'b0, read_valid = 1'b0, read_ready;
`ifdef WB_FIFO_PORT_ERR_EN
    logic       err_o;
`endif
    int checks = 0, failures = 0;

    wb_fifo_port dut (
        .clk(clk), .rst(rst), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
        .we_i(we_i), .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o),
`ifdef WB_FIFO_PORT_ERR_EN
        .err_o(err_o),
`endif
        .write_data(write_data), .write_valid(write_valid), .write_ready(write_ready),
        .read_data(read_data), .read_valid(read_valid), .read_ready(read_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [1:0] a, input logic [7:0] d,
                       output logic got, output int w, output logic [7:0] rd);
        @(negedge clk);
        chk("ack_gap", ack_o, 0);
        cyc_i = 1; stb_i = 1; we_i = we; adr_i = a; dat_i = d;
        got = 0; w = 0; rd = 'x;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (ack_o) begin got = 1; rd = dat_o; end else w++;
        end
        cyc_i = 0; stb_i = 0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        logic g; int w; logic [7:0] r;
        bus(1, a, d, g, w, r);
        chk("wr_ack_next_cycle", {g, 8'(w)}, {1'b1, 8'd0});
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic g; int w; logic [7:0] r;
        bus(0, a, 8'h00, g, w, r);
        chk({tag, "_ack"}, {g, 8'(w)}, {1'b1, 8'd0});
        chk(tag, r, exp);
    endtask

    task automatic start(input logic we, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        chk("ack_gap", ack_o, 0);
        cyc_i = 1; stb_i = 1; we_i = we; adr_i = a; dat_i = d;
    endtask

    initial begin
        logic g; int w; logic [7:0] r;
        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_ack", ack_o, 0);
        chk("rst_wvalid", write_valid, 0);
        chk("rst_rready", read_ready, 1);
        chk("rst_dat", dat_o, 0);

        // three writes stream out in order
        write_ready = 1;
        for (int i = 0; i < 3; i++) begin
            bus(1, 2'd0, 8'h41 + 8'(i), g, w, r);
            chk("tx_ack", {g, 8'(w)}, {1'b1, 8'd0});
            chk("tx_head", {write_valid, write_data}, {1'b1, 8'h41 + 8'(i)});
        end
        @(negedge clk);
        chk("tx_drained", write_valid, 0);

        // fill TX, last write stalls until one pop
        write_ready = 0;
        for (int i = 0; i < 16; i++) wr(2'd0, 8'(i));
        rd("tx_free_full", 2'd3, 8'd0);
        start(1, 2'd0, 8'h99);
        repeat (3) begin @(negedge clk); chk("tx_stall", ack_o, 0); end
        write_ready = 1;
        @(negedge clk);
        write_ready = 0;
        chk("tx_stall_ack", ack_o, 1);
        cyc_i = 0; stb_i = 0;
        rd("tx_free_after", 2'd3, 8'd0);
        chk("tx_head_after", write_data, 8'd1);

        // flush races a stream pop
        wr(2'd1, 8'h02);
        rd("tx_free_flushed", 2'd3, 8'd16);
        for (int i = 0; i < 8; i++) wr(2'd0, 8'hA0 + 8'(i));
        rd("tx_free_half", 2'd3, 8'd8);
        start(1, 2'd1, 8'h02);
        write_ready = 1;
        @(negedge clk);
        write_ready = 0;
        chk("flush_ack", ack_o, 1);
        cyc_i = 0; stb_i = 0;
        rd("flush_wins", 2'd3, 8'd16);
        chk("flush_wvalid", write_valid, 0);

        // RX overflow
        read_valid = 1;
        for (int i = 0; i < 17; i++) begin
            read_data = 8'h10 + 8'(i);
            @(negedge clk);
        end
        chk("rx_full_rready", read_ready, 0);
        read_valid = 0;
        rd("status_ovf", 2'd1, 8'h0F);
        rd("rx_count_full", 2'd2, 8'd16);
        wr(2'd1, 8'h01);
        rd("status_clr", 2'd1, 8'h07);
        rd("rx_first", 2'd0, 8'h10);
        rd("rx_second", 2'd0, 8'h11);
        rd("rx_count_after", 2'd2, 8'd14);
        wr(2'd2, 8'hFF);
        rd("rx_count_ro", 2'd2, 8'd14);
        wr(2'd1, 8'h02);
        rd("status_flushed", 2'd1, 8'h06);

        // read stalls on empty RX until data arrives
        start(0, 2'd0, 8'h00);
        repeat (3) begin @(negedge clk); chk("rx_stall", ack_o, 0); end
        read_valid = 1; read_data = 8'h5A;
        @(negedge clk);
        read_valid = 0;
        chk("rx_stall_push", ack_o, 0);
        @(negedge clk);
        chk("rx_stall_ack", {ack_o, dat_o}, {1'b1, 8'h5A});
        cyc_i = 0; stb_i = 0;
        rd("rx_count_zero", 2'd2, 8'd0);

        // reset in the middle of a stall
        wr(2'd0, 8'h77);
        chk("pre_rst_wvalid", write_valid, 1);
        start(0, 2'd0, 8'h00);
        @(negedge clk);
        chk("pre_rst_stall", ack_o, 0);
        rst = 1;
        @(negedge clk);
        rst = 0; cyc_i = 0; stb_i = 0;
        chk("mid_rst_ack", ack_o, 0);
        chk("mid_rst_wvalid", write_valid, 0);
        chk("mid_rst_rready", read_ready, 1);
        chk("mid_rst_dat", dat_o, 0);
        @(negedge clk);
        chk("post_rst_ack", ack_o, 0);
        rd("post_rst_status", 2'd1, 8'h06);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
